// File: rtl/alu_result_fifo_if.sv
// Result write beat from the ALU and FWFT read handshake toward the consumer.
// The master side drives the writes and rd_ready; the slave side is the FIFO.
interface alu_result_fifo_if #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned SEQ_W  = 8
);
    logic              valid_out;
    logic [DATA_W-1:0] alu;
    logic              carry;
    logic              zero;
    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_alu;
    logic              rd_carry;
    logic              rd_zero;
    logic [SEQ_W-1:0]  rd_seq;

    modport master (
        output valid_out, alu, carry, zero, rd_ready,
        input  rd_valid, rd_alu, rd_carry, rd_zero, rd_seq
    );

    modport slave (
        input  valid_out, alu, carry, zero, rd_ready,
        output rd_valid, rd_alu, rd_carry, rd_zero, rd_seq
    );
endinterface

// File: rtl/alu_result_fifo.sv
// FWFT result FIFO behind the 4-bit ALU with sequence tags and the cin flag register.
// Define ALU_RES_DROP_CNT_EN to add the saturating dropped-beat counter.
module alu_result_fifo #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned DATA_W = 4,
    parameter int unsigned SEQ_W  = 8,
    parameter int unsigned DROP_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    alu_result_fifo_if.slave         bus,
    input  logic                     flag_clr,
    output logic                     cin,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     overflow,
    output logic [DROP_W-1:0]        drop_cnt
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [DATA_W-1:0] alu;
        logic              carry;
        logic              zero;
        logic [SEQ_W-1:0]  seq;
    } entry_t;

    entry_t             mem_q [DEPTH];
    entry_t             mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [SEQ_W-1:0]   seq_q, seq_d;
    logic               full_q, full_d;
    logic               rd_valid_q, rd_valid_d;
    logic               cin_q, cin_d;
    logic               overflow_q, overflow_d;
    logic               push, pop, drop;

    // A full FIFO still accepts a write when the head leaves in the same cycle.
    always_comb begin
        pop  = rd_valid_q && bus.rd_ready;
        push = bus.valid_out && (!full_q || pop);
        drop = bus.valid_out && full_q && !pop;
    end

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        seq_d      = seq_q;
        cin_d      = cin_q;
        overflow_d = overflow_q || drop;

        if (push) begin
            mem_d[wr_ptr_q] = '{alu: bus.alu, carry: bus.carry, zero: bus.zero, seq: seq_q};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            seq_d           = seq_q + SEQ_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // Carry tracks every ALU beat, dropped or not; clear wins.
        if (flag_clr) begin
            cin_d = 1'b0;
        end else if (bus.valid_out) begin
            cin_d = bus.carry;
        end

        full_d     = (count_d == CNT_W'(DEPTH));
        rd_valid_d = (count_d != '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            seq_q      <= '0;
            full_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            cin_q      <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            seq_q      <= seq_d;
            full_q     <= full_d;
            rd_valid_q <= rd_valid_d;
            cin_q      <= cin_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef ALU_RES_DROP_CNT_EN
    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

    // Saturates rather than wrapping so a large count is never mistaken for a small one.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + DROP_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`else
    assign drop_cnt = '0;
`endif

    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_alu   = mem_q[rd_ptr_q].alu;
    assign bus.rd_carry = mem_q[rd_ptr_q].carry;
    assign bus.rd_zero  = mem_q[rd_ptr_q].zero;
    assign bus.rd_seq   = mem_q[rd_ptr_q].seq;
    assign cin          = cin_q;
    assign count        = count_q;
    assign full         = full_q;
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_alu_result_fifo.sv
// Self-checking bench for alu_result_fifo: directed vector table plus fill/drop,
// full-with-pop, tag wrap and asynchronous reset sequences.
module tb_alu_result_fifo;
    logic       clk = 1'b0;
    logic       reset;
    logic       flag_clr;
    logic       cin;
    logic [3:0] count;
    logic       full;
    logic       overflow;
    logic [7:0] drop_cnt;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef ALU_RES_DROP_CNT_EN
    localparam logic [7:0] DROP_ONE = 8'd1;
`else
    localparam logic [7:0] DROP_ONE = 8'd0;
`endif

    alu_result_fifo_if #(.DATA_W(4), .SEQ_W(8)) bus ();

    alu_result_fifo #(.DEPTH(8), .DATA_W(4), .SEQ_W(8), .DROP_W(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .flag_clr (flag_clr),
        .cin      (cin),
        .count    (count),
        .full     (full),
        .overflow (overflow),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       vo;
        logic [3:0] alu;
        logic       c;
        logic       z;
        logic       clr;
        logic       rdy;
        logic       e_v;
        logic [3:0] e_alu;
        logic       e_c;
        logic       e_z;
        logic [7:0] e_seq;
        logic [3:0] e_cnt;
        logic       e_full;
        logic       e_cin;
        logic       e_ovf;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic vo, input logic [3:0] alu, input logic c,
                         input logic z, input logic clr, input logic rdy);
        @(negedge clk);
        bus.valid_out = vo;
        bus.alu       = alu;
        bus.carry     = c;
        bus.zero      = z;
        flag_clr      = clr;
        bus.rd_ready  = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.valid_out = 1'b0;
        bus.rd_ready  = 1'b0;
        flag_clr      = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus.valid_out = 1'b0;
        bus.alu       = '0;
        bus.carry     = 1'b0;
        bus.zero      = 1'b0;
        bus.rd_ready  = 1'b0;
        flag_clr      = 1'b0;

        //            vo alu    c  z clr rdy | v  alu    c  z  seq   cnt  full cin ovf
        vecs[0] = '{1, 4'hA, 1, 0, 0, 0,  1, 4'hA, 1, 0, 8'd0, 4'd1, 0, 1, 0};
        vecs[1] = '{1, 4'h3, 0, 0, 0, 0,  1, 4'hA, 1, 0, 8'd0, 4'd2, 0, 0, 0};
        vecs[2] = '{0, 4'h0, 0, 0, 0, 1,  1, 4'h3, 0, 0, 8'd1, 4'd1, 0, 0, 0};
        vecs[3] = '{1, 4'h0, 0, 1, 0, 1,  1, 4'h0, 0, 1, 8'd2, 4'd1, 0, 0, 0};
        vecs[4] = '{0, 4'h0, 0, 0, 0, 1,  0, 4'h0, 0, 0, 8'd0, 4'd0, 0, 0, 0};
        vecs[5] = '{0, 4'h0, 0, 0, 0, 1,  0, 4'h0, 0, 0, 8'd0, 4'd0, 0, 0, 0};
        vecs[6] = '{1, 4'h5, 1, 0, 1, 1,  1, 4'h5, 1, 0, 8'd3, 4'd1, 0, 0, 0};
        vecs[7] = '{1, 4'h6, 1, 0, 0, 0,  1, 4'h5, 1, 0, 8'd3, 4'd2, 0, 1, 0};
        vecs[8] = '{0, 4'h0, 0, 0, 1, 1,  1, 4'h6, 1, 0, 8'd4, 4'd1, 0, 0, 0};
        vecs[9] = '{0, 4'h0, 0, 0, 0, 1,  0, 4'h0, 0, 0, 8'd0, 4'd0, 0, 0, 0};

        do_reset();
        #1;
        chk("rst_count",    32'(count),        32'd0);
        chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("rst_full",     32'(full),         32'd0);
        chk("rst_cin",      32'(cin),          32'd0);
        chk("rst_overflow", 32'(overflow),     32'd0);
        chk("rst_rd_alu",   32'(bus.rd_alu),   32'd0);
        chk("rst_rd_seq",   32'(bus.rd_seq),   32'd0);
        chk("rst_drop_cnt", 32'(drop_cnt),     32'd0);

        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].vo, vecs[i].alu, vecs[i].c, vecs[i].z, vecs[i].clr, vecs[i].rdy);
            chk($sformatf("vec%0d_rd_valid", i), 32'(bus.rd_valid), 32'(vecs[i].e_v));
            chk($sformatf("vec%0d_count", i),    32'(count),        32'(vecs[i].e_cnt));
            chk($sformatf("vec%0d_full", i),     32'(full),         32'(vecs[i].e_full));
            chk($sformatf("vec%0d_cin", i),      32'(cin),          32'(vecs[i].e_cin));
            chk($sformatf("vec%0d_overflow", i), 32'(overflow),     32'(vecs[i].e_ovf));
            if (vecs[i].e_v) begin
                chk($sformatf("vec%0d_rd_alu", i),   32'(bus.rd_alu),   32'(vecs[i].e_alu));
                chk($sformatf("vec%0d_rd_carry", i), 32'(bus.rd_carry), 32'(vecs[i].e_c));
                chk($sformatf("vec%0d_rd_zero", i),  32'(bus.rd_zero),  32'(vecs[i].e_z));
                chk($sformatf("vec%0d_rd_seq", i),   32'(bus.rd_seq),   32'(vecs[i].e_seq));
            end
        end

        // Fill to DEPTH, then a ninth beat is dropped.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 4'(i), 1'b0, 1'b0, 1'b0, 1'b0);
        end
        chk("fill_count",    32'(count),    32'd8);
        chk("fill_full",     32'(full),     32'd1);
        chk("fill_overflow", 32'(overflow), 32'd0);
        chk("fill_cin",      32'(cin),      32'd0);
        drive(1'b1, 4'hE, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("drop_count",    32'(count),      32'd8);
        chk("drop_overflow", 32'(overflow),   32'd1);
        chk("drop_cnt",      32'(drop_cnt),   32'(DROP_ONE));
        chk("drop_cin",      32'(cin),        32'd1);
        chk("drop_head_alu", 32'(bus.rd_alu), 32'd0);
        chk("drop_head_seq", 32'(bus.rd_seq), 32'd0);

        // Full with simultaneous pop: write accepted, takes tag 8.
        drive(1'b1, 4'hF, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("fullpop_count",    32'(count),      32'd8);
        chk("fullpop_full",     32'(full),       32'd1);
        chk("fullpop_head_alu", 32'(bus.rd_alu), 32'd1);
        chk("fullpop_head_seq", 32'(bus.rd_seq), 32'd1);
        for (int i = 1; i < 9; i++) begin
            chk($sformatf("drain%0d_alu", i), 32'(bus.rd_alu), (i == 8) ? 32'hF : 32'(i));
            chk($sformatf("drain%0d_seq", i), 32'(bus.rd_seq), 32'(i));
            drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        chk("drain_count",    32'(count),        32'd0);
        chk("drain_rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("drain_overflow", 32'(overflow),     32'd1);

        // 300 beats streamed through: tag wraps 255 -> 0, occupancy stays at 1.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 4'(i), i[0], 1'b0, 1'b0, 1'b1);
            chk($sformatf("wrap%0d_count", i), 32'(count),      32'd1);
            chk($sformatf("wrap%0d_alu", i),   32'(bus.rd_alu), 32'(i % 16));
            chk($sformatf("wrap%0d_seq", i),   32'(bus.rd_seq), 32'(i % 256));
        end
        drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("wrap_end_count",    32'(count),    32'd0);
        chk("wrap_end_overflow", 32'(overflow), 32'd0);

        // Asynchronous reset with five entries, overflow and cin set.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 4'(i + 3), 1'b1, 1'b0, 1'b0, 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        bus.rd_ready = 1'b0;
        chk("pre_arst_count",    32'(count),    32'd5);
        chk("pre_arst_overflow", 32'(overflow), 32'd1);
        chk("pre_arst_cin",      32'(cin),      32'd1);
        #2 reset = 1'b1;
        #1;
        chk("arst_count",    32'(count),        32'd0);
        chk("arst_rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("arst_cin",      32'(cin),          32'd0);
        chk("arst_overflow", 32'(overflow),     32'd0);
        chk("arst_drop_cnt", 32'(drop_cnt),     32'd0);
        chk("arst_rd_alu",   32'(bus.rd_alu),   32'd0);
        @(negedge clk);
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
